// File: rtl/single_port_ram_ctrl.sv
// single_port_ram_ctrl: parametrised single-port RAM with byte enables, read-during-write mode, optional output register and clear-after-reset sequencer
// Ports: clk/rst (sync, active-high), cs/we/be/addr/din access request,
//        dout/dout_valid read result (1 or 2 cycle latency), busy while clearing.
module single_port_ram_ctrl #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 10,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  busy
);
    localparam int NB = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $fatal(1, "DATA_W must be a multiple of 8");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W:0]   clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] rd_q, rd_d, out_q, out_d, old_word, merged, wr_data;
    logic              rd_vld_q, rd_vld_d, out_vld_q, acc, wr_en;
    logic [ADDR_W-1:0] wr_addr;

    assign busy     = state_q == CLEAR;
    assign acc      = cs & ~busy & ~rst;
    assign old_word = mem[addr];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++)
            if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
    end

    // The clear sequencer and user writes share the single write port; busy gates users out.
    always_comb begin
        wr_en      = busy ? ~rst : acc & we;
        wr_addr    = busy ? clr_addr_q[ADDR_W-1:0] : addr;
        wr_data    = busy ? '0 : merged;
        rd_d       = acc ? ((we && RDW_MODE != 0) ? merged : old_word) : rd_q;
        rd_vld_d   = acc;
        out_d      = rd_vld_q ? rd_q : out_q;
        clr_addr_d = busy ? clr_addr_q + 1'b1 : clr_addr_q;
        state_d    = (busy && clr_addr_q == LAST) ? IDLE : state_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
            clr_addr_q <= '0;
            rd_q       <= '0;
            rd_vld_q   <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rd_q       <= rd_d;
            rd_vld_q   <= rd_vld_d;
            out_q      <= out_d;
            out_vld_q  <= rd_vld_q;
        end
    end

    assign dout       = OUT_REG != 0 ? out_q : rd_q;
    assign dout_valid = OUT_REG != 0 ? out_vld_q : rd_vld_q;
endmodule

// File: doc/single_port_ram_ctrl.md
Name: single_port_ram_ctrl

Overview:
- Parametrised synchronous single-port RAM for the SD142 memory labs, replacing the fixed 1024x8 RAM.
- Generic data width and depth, per-byte write enables and a selectable read-during-write mode.
- Optional output pipeline register with a valid strobe, and an optional hardware clear sequencer that zeroes every word after reset.
- Sits between a simple bus master (testbench, datapath or lab CPU) and on-chip block RAM.

Parameters:
- DATA_W, 8: word width in bits; must be a multiple of 8.
- ADDR_W, 10: address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0: read-during-write mode. 0 = read-first (old data). 1 = write-first (new data in enabled byte lanes, old data elsewhere).
- OUT_REG, 0: 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
- CLEAR_ON_RESET, 1: 1 = zero all DEPTH words after reset; 0 = memory contents untouched by reset.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- cs, input, 1: chip select; an access happens only when cs=1 and busy=0.
- we, input, 1: 1 = write, 0 = read (qualified by cs).
- be, input, DATA_W/8: byte enables for writes; bit i controls din[8i+7:8i]. Ignored on reads.
- addr, input, ADDR_W: word address.
- din, input, DATA_W: write data.
- dout, output, DATA_W: read data; holds its last value between reads and is never Z.
- dout_valid, output, 1: one-cycle pulse marking dout as carrying data for an accepted access.
- busy, output, 1: 1 while the clear sequencer runs; accesses are ignored.

Behaviour:
- Accept condition: acc = cs & ~busy & ~rst, sampled at the rising edge.
- Write (acc & we):
  - For each i with be[i]=1: mem[addr] byte i <= din byte i.
  - Lanes with be[i]=0 are unchanged.
  - If be is all zero, no memory change, but dout_valid still pulses.
- Read (acc & ~we): mem[addr] is captured into the read stage.
- Every accepted access, read or write, produces read data.
  - On a write, the captured data follows RDW_MODE.
  - RDW_MODE=0: the pre-write word.
  - RDW_MODE=1: the merged word, with din in enabled lanes and old data in the others.
- Latency:
  - OUT_REG=0: dout and dout_valid update on the same edge that accepts the access, so they are visible in the next cycle.
  - OUT_REG=1: one more register stage, visible two cycles after acceptance.
  - Back-to-back accesses give one result per cycle, with no bubbles.
- No access (cs=0, or busy=1): dout holds its previous value and dout_valid=0. A pipelined result already in flight with OUT_REG=1 still completes.
- Reset (rst=1 at an edge):
  - dout <= 0, dout_valid <= 0, and the pipeline is flushed.
  - The clear address counter is set to 0.
  - State <= CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy = (state==CLEAR). It is therefore 1 from the first reset edge when CLEAR_ON_RESET=1.
- State machine, two states:
  - IDLE: normal operation; busy=0.
  - CLEAR: on each edge with rst=0, write 0 to mem[clr_addr] and increment clr_addr. When clr_addr == DEPTH-1 is written, go to IDLE.
  - busy therefore stays high for exactly DEPTH cycles after rst deasserts.
- rst asserted during CLEAR restarts the sequence from address 0.
- cs/we asserted while busy=1: fully ignored. No memory write, no dout_valid, no queuing.
- Address wrap: the clear counter is ADDR_W+1 bits or has explicit compare logic, so it never wraps silently. The user addr is natural ADDR_W-bit indexing, with no out-of-range case.
- CLEAR_ON_RESET=0: reset affects only dout, dout_valid, the pipeline and the state (IDLE). Memory retains its contents across reset.
- Elaboration check: DATA_W % 8 != 0 is a fatal error.

Test Plan:
1. Defaults (8/10, RDW 0, OUT_REG 0, CLEAR 1): pulse rst for 2 cycles, then release.
   - busy=1 for exactly 1024 cycles after release, then 0.
   - A read of addr 0x3FF then returns dout=0x00 with dout_valid one cycle later.
2. After the clear: write 0xA5 to addr 5, then read addr 5 on the next cycle.
   - The read returns dout=0xA5 and dout_valid=1 one cycle after the read is accepted.
   - With cs=0 afterwards, dout holds 0xA5 and dout_valid=0.
3. DATA_W=32, mem[2]=0x11223344: write din=0xAABBCCDD, be=4'b0101 to addr 2.
   - RDW_MODE=0: write-cycle dout=0x11223344, then a read gives 0x11BB33DD.
   - RDW_MODE=1: write-cycle dout=0x11BB33DD.
4. OUT_REG=1: read addrs 1,2,3 on consecutive cycles holding 0x10,0x20,0x30.
   - dout shows 0x10,0x20,0x30 on cycles 2,3,4 after the first accept.
   - dout_valid is high for 3 consecutive cycles.
5. During CLEAR (busy=1): drive cs=1, we=1, addr=7, din=0xFF. Assert rst at clear cycle 500.
   - No dout_valid during CLEAR.
   - Clear restarts; busy stays high for 1024 cycles after the second rst release.
   - mem[7] reads 0x00 afterwards.
6. CLEAR_ON_RESET=0: write 0x5A to addr 9, pulse rst.
   - busy stays 0.
   - dout=0 right after reset; reading addr 9 returns 0x5A.
